ch_adv_decoder: RTL and testbench

// - Upstream feeder of the known-CH selector. Consumes the received-packet word stream, parses

---
 rtl/ch_adv_decoder_pkg.sv | 21 ++
 rtl/ch_adv_decoder_if.sv | 26 ++
 rtl/ch_adv_decoder_sat_counter.sv | 27 ++
 rtl/ch_adv_decoder.sv | 165 ++++++++++++++++
 tb/tb_ch_adv_decoder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ch_adv_decoder_pkg.sv
// Shared definitions for the cluster-head advertisement decoder.
// Message types, header field positions and the parser state encoding.
package ch_adv_decoder_pkg;

    localparam int HDR_TYPE_LSB = 12;
    localparam int HDR_TYPE_W   = 4;

    localparam logic [HDR_TYPE_W-1:0] MSG_ADV = 4'h1;
    localparam logic [HDR_TYPE_W-1:0] MSG_HB  = 4'h2;

    typedef enum logic [2:0] {
        S_HDR,
        S_ID,
        S_HOPS,
        S_QV,
        S_FLUSH,
        S_EMIT_ADV,
        S_EMIT_HB
    } state_t;

endpackage

// File: rtl/ch_adv_decoder_if.sv
// Received-packet word stream with valid/ready handshake.
// The packet source is the master; the decoder is the slave.
interface ch_adv_decoder_if #(
    parameter int WORD_WIDTH = 16
) ();

    logic                  in_valid;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_last;
    logic                  in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/ch_adv_decoder_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Used for the decoder's receive and drop statistics.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;

    // Count one event per strobe until the counter is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ch_adv_decoder.sv
// Parses CH advertisements and heartbeats from the packet stream and
// drives the known-CH selector inputs plus receive/drop statistics.
module ch_adv_decoder
    import ch_adv_decoder_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] my_id,
    ch_adv_decoder_if.slave       s_if,
    output logic                  en_KCH,
    output logic [WORD_WIDTH-1:0] fCH_ID,
    output logic [WORD_WIDTH-1:0] fCH_Hops,
    output logic [WORD_WIDTH-1:0] fCH_QValue,
    output logic                  HB_reset,
    output logic [CNT_WIDTH-1:0]  adv_count,
    output logic [CNT_WIDTH-1:0]  drop_count
);

    localparam logic [WORD_WIDTH-1:0] W_ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic [WORD_WIDTH-1:0] id_q;
    logic [WORD_WIDTH-1:0] hops_q;
    logic [WORD_WIDTH-1:0] fch_id_q;
    logic [WORD_WIDTH-1:0] fch_hops_q;
    logic [WORD_WIDTH-1:0] fch_q_q;
    logic                  en_kch_q;
    logic                  hb_reset_q;

    logic                  acc;
    logic                  last;
    logic [HDR_TYPE_W-1:0] msg_type;
    logic                  adv_d;
    logic                  drop_d;
    logic [WORD_WIDTH-1:0] hops_inc;

    assign acc      = s_if.in_valid && s_if.in_ready;
    assign last     = s_if.in_last;
    assign msg_type = s_if.in_data[HDR_TYPE_LSB +: HDR_TYPE_W];
    assign hops_inc = (hops_q == '1) ? hops_q : hops_q + W_ONE;

    // Emit states stall the stream; reset holds it off entirely.
    always_comb begin
        s_if.in_ready = 1'b0;
        if (!rst) begin
            s_if.in_ready = (state_q != S_EMIT_ADV) &&
                            (state_q != S_EMIT_HB);
        end
    end

    // Decide, per accepted word, whether the packet completes or is dropped.
    always_comb begin
        adv_d  = 1'b0;
        drop_d = 1'b0;
        if (acc) begin
            unique case (state_q)
                S_HDR: begin
                    if (msg_type == MSG_ADV) begin
                        drop_d = last;
                    end else if (msg_type == MSG_HB) begin
                        drop_d = !last;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                S_ID, S_HOPS: drop_d = last;
                S_QV: begin
                    if (last && (id_q != my_id)) begin
                        adv_d = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packet parser with registered selector outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HDR;
            id_q       <= '0;
            hops_q     <= '0;
            fch_id_q   <= '1;
            fch_hops_q <= '1;
            fch_q_q    <= '0;
            en_kch_q   <= 1'b0;
            hb_reset_q <= 1'b0;
        end else begin
            en_kch_q   <= 1'b0;
            hb_reset_q <= 1'b0;
            unique case (state_q)
                S_HDR: begin
                    if (acc) begin
                        if (msg_type == MSG_ADV) begin
                            state_q <= last ? S_HDR : S_ID;
                        end else if (msg_type == MSG_HB) begin
                            state_q    <= last ? S_EMIT_HB : S_FLUSH;
                            hb_reset_q <= last;
                        end else begin
                            state_q <= last ? S_HDR : S_FLUSH;
                        end
                    end
                end
                S_ID: begin
                    if (acc) begin
                        id_q    <= s_if.in_data;
                        state_q <= last ? S_HDR : S_HOPS;
                    end
                end
                S_HOPS: begin
                    if (acc) begin
                        hops_q  <= s_if.in_data;
                        state_q <= last ? S_HDR : S_QV;
                    end
                end
                S_QV: begin
                    if (acc) begin
                        if (adv_d) begin
                            fch_id_q   <= id_q;
                            fch_hops_q <= hops_inc;
                            fch_q_q    <= s_if.in_data;
                            en_kch_q   <= 1'b1;
                            state_q    <= S_EMIT_ADV;
                        end else begin
                            state_q <= last ? S_HDR : S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (acc && last) begin
                        state_q <= S_HDR;
                    end
                end
                S_EMIT_ADV, S_EMIT_HB: state_q <= S_HDR;
                default: state_q <= S_HDR;
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_adv_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (adv_d),
        .cnt_o (adv_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (drop_d),
        .cnt_o (drop_count)
    );

    assign en_KCH     = en_kch_q;
    assign HB_reset   = hb_reset_q;
    assign fCH_ID     = fch_id_q;
    assign fCH_Hops   = fch_hops_q;
    assign fCH_QValue = fch_q_q;

endmodule

// File: tb/tb_ch_adv_decoder.sv
// Randomized bench for ch_adv_decoder against a packet-level model.
// Each packet is classified as a whole; outputs checked after it ends.
module tb_ch_adv_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] my_id;
    logic        en_KCH;
    logic [15:0] fCH_ID;
    logic [15:0] fCH_Hops;
    logic [15:0] fCH_QValue;
    logic        HB_reset;
    logic [7:0]  adv_count;
    logic [7:0]  drop_count;

    ch_adv_decoder_if #(.WORD_WIDTH(16)) s_if ();

    ch_adv_decoder #(
        .WORD_WIDTH (16),
        .CNT_WIDTH  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_id      (my_id),
        .s_if       (s_if),
        .en_KCH     (en_KCH),
        .fCH_ID     (fCH_ID),
        .fCH_Hops   (fCH_Hops),
        .fCH_QValue (fCH_QValue),
        .HB_reset   (HB_reset),
        .adv_count  (adv_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_id;
    logic [15:0] exp_hops;
    logic [15:0] exp_q;
    int          exp_adv;
    int          exp_drop;
    int          exp_en_total = 0;
    int          exp_hb_total = 0;
    int          en_seen = 0;
    int          hb_seen = 0;

    logic [15:0] pkt[$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counting is kept apart from the per-packet checks so that
    // stray or stretched pulses show up in the final totals.
    always @(negedge clk) begin
        if (en_KCH) en_seen++;
        if (HB_reset) hb_seen++;
        if (en_KCH && HB_reset) check("pulse_excl", 32'd1, 32'd0);
    end

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_reset();
        exp_id   = 16'hFFFF;
        exp_hops = 16'hFFFF;
        exp_q    = 16'h0000;
        exp_adv  = 0;
        exp_drop = 0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_id"},   fCH_ID,     exp_id);
        check({tag, "_hops"}, fCH_Hops,   exp_hops);
        check({tag, "_q"},    fCH_QValue, exp_q);
        check({tag, "_adv"},  adv_count,  exp_adv);
        check({tag, "_drop"}, drop_count, exp_drop);
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int  n;
        bit  done;
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        s_if.in_last  = l;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (s_if.in_ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 20) begin
                    check("ready_timeout", 32'd0, 32'd1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        s_if.in_valid = 1'b0;
        s_if.in_last  = 1'b0;
        s_if.in_data  = 16'($urandom);
    endtask

    task automatic run_pkt(input string tag);
        logic [15:0] w0;
        logic [3:0]  typ;
        bit          is_adv;
        bit          is_hb;
        int          len;
        len = pkt.size();
        for (int i = 0; i < len; i++) begin
            send_word(pkt[i], (i == len - 1));
        end
        w0     = pkt[0];
        typ    = w0[15:12];
        is_adv = (typ == 4'h1) && (len == 4) && (pkt[1] != my_id);
        is_hb  = (typ == 4'h2) && (len == 1);
        if (is_adv) begin
            exp_id   = pkt[1];
            exp_hops = (pkt[2] == 16'hFFFF) ? 16'hFFFF : pkt[2] + 16'd1;
            exp_q    = pkt[3];
            exp_adv  = sat8(exp_adv + 1);
            exp_en_total++;
        end else if (is_hb) begin
            exp_hb_total++;
        end else begin
            exp_drop = sat8(exp_drop + 1);
        end
        @(negedge clk);
        check({tag, "_en"},    en_KCH,      is_adv);
        check({tag, "_hb"},    HB_reset,    is_hb);
        check({tag, "_ready"}, s_if.in_ready, !(is_adv || is_hb));
        check_idle(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic gen_pkt(input int kind);
        int          len;
        logic [15:0] id;
        logic [3:0]  t;
        pkt.delete();
        case (kind)
            0, 1, 2, 3: begin
                id = 16'($urandom);
                while (id == my_id) id = 16'($urandom);
                if (kind == 3) id = my_id;
                pkt.push_back({4'h1, 12'($urandom)});
                pkt.push_back(id);
                case ($urandom_range(0, 7))
                    0, 1:    pkt.push_back(16'hFFFF);
                    2:       pkt.push_back(16'hFFFE);
                    3:       pkt.push_back(16'h0000);
                    default: pkt.push_back(16'($urandom));
                endcase
                pkt.push_back(16'($urandom));
            end
            4: pkt.push_back({4'h2, 12'($urandom)});
            5: begin
                pkt.push_back({4'h2, 12'($urandom)});
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) pkt.push_back(16'($urandom));
            end
            6, 7: begin
                len = (kind == 6) ? $urandom_range(1, 3) : $urandom_range(5, 6);
                pkt.push_back({4'h1, 12'($urandom)});
                for (int i = 1; i < len; i++) pkt.push_back(16'($urandom));
            end
            default: begin
                t = 4'($urandom);
                while (t == 4'h1 || t == 4'h2) t = 4'($urandom);
                len = $urandom_range(1, 4);
                pkt.push_back({t, 12'($urandom)});
                for (int i = 1; i < len; i++) pkt.push_back(16'($urandom));
            end
        endcase
    endtask

    initial begin
        rst           = 1'b1;
        my_id         = 16'h0001;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 16'h0000;
        s_if.in_last  = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check("rst_ready", s_if.in_ready, 1'b0);
        check("rst_en",    en_KCH,        1'b0);
        check("rst_hb",    HB_reset,      1'b0);
        check_idle("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", s_if.in_ready, 1'b1);
        @(posedge clk);
        #1;

        pkt = '{16'h1000, 16'h0007, 16'h0002, 16'h0050};
        run_pkt("adv_basic");
        pkt = '{16'h1000, 16'h0012, 16'hFFFF, 16'h0033};
        run_pkt("adv_hops_sat");
        my_id = 16'h0007;
        pkt = '{16'h1000, 16'h0007, 16'h0001, 16'h0099};
        run_pkt("adv_own_id");
        pkt = '{16'h2000};
        run_pkt("hb");
        pkt = '{16'h2000, 16'h1234};
        run_pkt("hb_long");
        pkt = '{16'h1000, 16'h0021, 16'h0004};
        run_pkt("adv_trunc");
        pkt = '{16'h1000, 16'h0022, 16'h0004, 16'h0010, 16'h0011};
        run_pkt("adv_long");
        pkt = '{16'h1ABC, 16'h0023, 16'h0005, 16'h0077};
        run_pkt("adv_after");
        pkt = '{16'h9000, 16'h0001, 16'h0002};
        run_pkt("unknown9");

        for (int k = 0; k < 200; k++) begin
            if ((k % 25) == 0) my_id = 16'($urandom);
            gen_pkt($urandom_range(0, 9));
            run_pkt("rand");
        end

        for (int k = 0; k < 300; k++) begin
            pkt = '{16'h9000};
            run_pkt("drop_sat");
        end
        check("drop_full", drop_count, 8'hFF);

        my_id = 16'h0007;
        send_word(16'h1000, 1'b0);
        send_word(16'h0005, 1'b0);
        s_if.in_valid = 1'b1;
        s_if.in_data  = 16'h0003;
        s_if.in_last  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("mid_rst_ready", s_if.in_ready, 1'b0);
        check_idle("mid_rst");
        @(posedge clk);
        #1;
        s_if.in_valid = 1'b0;
        rst           = 1'b0;
        @(negedge clk);
        check("mid_rst_ready1", s_if.in_ready, 1'b1);
        @(posedge clk);
        #1;
        pkt = '{16'h1000, 16'h0044, 16'h0008, 16'h0123};
        run_pkt("adv_post_rst");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("en_total", en_seen, exp_en_total);
        check("hb_total", hb_seen, exp_hb_total);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
